// File: rtl/prio_enc_scan_if.sv
// Bundles the encoder controls, request vector and display outputs of prio_enc_scan.
// The master modport drives requests; the slave modport is the encoder/display side.
interface prio_enc_scan_if #(
   parameter int N_IN   = 16,
   parameter int DIGITS = 2
);
   localparam int IDX_W = $clog2(N_IN);

   logic              en;
   logic              clr;
   logic [N_IN-1:0]   x;
   logic [IDX_W-1:0]  y;
   logic              valid;
   logic              changed;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;

   modport master (
      output en, clr, x,
      input  y, valid, changed, seg, an
   );

   modport slave (
      input  en, clr, x,
      output y, valid, changed, seg, an
   );
endinterface

// File: rtl/prio_enc_scan.sv
// Registered N-input priority encoder driving a multiplexed common-anode 7-seg hex display.
// Define PRIO_ENC_STICKY_EN to hold the largest index seen since reset/clr (clr then becomes active).
module prio_enc_scan #(
   parameter int N_IN     = 16,
   parameter int DIGITS   = 2,
   parameter int SCAN_DIV = 1024
) (
   input  logic           clk_i,
   input  logic           rst_i,
   prio_enc_scan_if.slave bus
);
   localparam int IDX_W = $clog2(N_IN);
   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int NIB_W = DIGITS * 4;

   logic [IDX_W-1:0] hi_idx;
   logic             req_any;
   logic [IDX_W-1:0] y_d, y_q;
   logic             valid_d, valid_q;
   logic             changed_q;

   // Ascending scan so the last hit (highest index) wins.
   always_comb begin
      hi_idx = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (bus.x[i]) hi_idx = IDX_W'(i);
      end
   end

   assign req_any = |bus.x;

`ifdef PRIO_ENC_STICKY_EN
   // y_q doubles as the sticky max register.
   always_comb begin
      y_d     = y_q;
      valid_d = valid_q;
      if (bus.en) begin
         if (bus.clr) begin
            y_d     = '0;
            valid_d = 1'b0;
         end else if (req_any) begin
            valid_d = 1'b1;
            y_d     = (valid_q && (y_q > hi_idx)) ? y_q : hi_idx;
         end
      end
   end
`else
   logic unused_clr;
   assign unused_clr = bus.clr;

   always_comb begin
      y_d     = y_q;
      valid_d = 1'b0;
      if (bus.en) begin
         valid_d = req_any;
         y_d     = req_any ? hi_idx : '0;
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         y_q       <= '0;
         valid_q   <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         y_q       <= y_d;
         valid_q   <= valid_d;
         changed_q <= ({valid_d, y_d} != {valid_q, y_q});
      end
   end

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [DIG_W-1:0] dig_d, dig_q;
   logic             scan_on_q;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      dig_d = dig_q;
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
      end
   end

   // scan_on_q keeps all anodes off until the first edge after reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         dig_q     <= '0;
         scan_on_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         dig_q     <= dig_d;
         scan_on_q <= 1'b1;
      end
   end

   logic [NIB_W-1:0] y_ext;
   logic [3:0]       nib;
   logic [6:0]       glyph;

   always_comb begin
      y_ext             = '0;
      y_ext[IDX_W-1:0]  = y_q;
      nib               = y_ext[{dig_q, 2'b00} +: 4];
      case (nib)
         4'h0:    glyph = 7'h40;
         4'h1:    glyph = 7'h79;
         4'h2:    glyph = 7'h24;
         4'h3:    glyph = 7'h30;
         4'h4:    glyph = 7'h19;
         4'h5:    glyph = 7'h12;
         4'h6:    glyph = 7'h02;
         4'h7:    glyph = 7'h78;
         4'h8:    glyph = 7'h00;
         4'h9:    glyph = 7'h10;
         4'hA:    glyph = 7'h08;
         4'hB:    glyph = 7'h03;
         4'hC:    glyph = 7'h46;
         4'hD:    glyph = 7'h21;
         4'hE:    glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   end

   assign bus.y       = y_q;
   assign bus.valid   = valid_q;
   assign bus.changed = changed_q;
   assign bus.seg     = valid_q ? glyph : 7'h7F;
   assign bus.an      = scan_on_q ? ~(DIGITS'(1) << dig_q) : '1;
endmodule
